// File: rtl/alu_core_pipe_if.sv
// Instruction and result ports of alu_core_pipe. Both sides are valid/ready:
// a beat transfers on a rising edge where valid && ready; a producer must hold
// its payload stable while valid is high and ready is low.
interface alu_core_pipe_if #(
    parameter int DATA_WIDTH = 8
);
    logic [31:0]           i_instr;
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_data1;
    logic                  o_valid1;
    logic                  i_ready1;
    logic [1:0]            o_flags;
    logic [4:0]            o_rd;
    logic                  o_err;

    modport master (
        output i_instr, i_valid, i_ready1,
        input  o_ready, o_data1, o_valid1, o_flags, o_rd, o_err
    );

    modport slave (
        input  i_instr, i_valid, i_ready1,
        output o_ready, o_data1, o_valid1, o_flags, o_rd, o_err
    );
endinterface

// File: rtl/alu_core_pipe.sv
// Two-stage ALU: S1 holds one issued instruction, EX reads the register file,
// computes and retires into a back-pressurable output register.
module alu_core_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 32
) (
    input  logic           i_CLK,
    input  logic           i_RSTn,
    alu_core_pipe_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_LDI  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;

    logic                  s1_valid_q, s1_valid_d;
    logic [31:0]           s1_instr_q, s1_instr_d;
    logic [DATA_WIDTH-1:0] rf_q [1:REG_COUNT-1];

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]            out_flags_q, out_flags_d;
    logic [4:0]            out_rd_q, out_rd_d;
    logic                  out_err_q, out_err_d;

    logic [3:0]            op;
    logic [4:0]            rd, rs1, rs2;
    logic [12:0]           imm;
    logic [DATA_WIDTH-1:0] op_a, op_b, imm_t;
    logic [DATA_WIDTH:0]   add_w, sub_w, addi_w;
    logic                  shift_big;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_c, alu_err;
    logic                  ready, accept, retire, rf_we;

    assign op    = s1_instr_q[31:28];
    assign rd    = s1_instr_q[27:23];
    assign rs1   = s1_instr_q[22:18];
    assign rs2   = s1_instr_q[17:13];
    assign imm   = s1_instr_q[12:0];
    assign imm_t = DATA_WIDTH'(imm);

    // R0 and indices beyond REG_COUNT have no storage and read as zero.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            if (rs1 == 5'(i)) op_a = rf_q[i];
            if (rs2 == 5'(i)) op_b = rf_q[i];
        end
    end

    assign add_w     = {1'b0, op_a} + {1'b0, op_b};
    assign sub_w     = {1'b0, op_a} - {1'b0, op_b};
    assign addi_w    = {1'b0, op_a} + {1'b0, imm_t};
    assign shift_big = 32'(op_b) >= DATA_WIDTH;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_err = 1'b0;
        case (op)
            OP_ADD:  begin alu_res = add_w[DATA_WIDTH-1:0];  alu_c = add_w[DATA_WIDTH];  end
            OP_SUB:  begin alu_res = sub_w[DATA_WIDTH-1:0];  alu_c = sub_w[DATA_WIDTH];  end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SHL:  alu_res = shift_big ? '0 : (op_a << op_b);
            OP_SHR:  alu_res = shift_big ? '0 : (op_a >> op_b);
            OP_LDI:  alu_res = imm_t;
            OP_ADDI: begin alu_res = addi_w[DATA_WIDTH-1:0]; alu_c = addi_w[DATA_WIDTH]; end
            default: alu_err = 1'b1;
        endcase
    end

    assign ready  = !s1_valid_q || !out_valid_q || bus.i_ready1;
    assign accept = bus.i_valid && ready;
    assign retire = s1_valid_q && (!out_valid_q || bus.i_ready1);
    assign rf_we  = retire && !alu_err && (rd != 5'd0);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_instr_d  = s1_instr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        out_rd_d    = out_rd_q;
        out_err_d   = out_err_q;
        if (retire) s1_valid_d = 1'b0;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_instr_d = bus.i_instr;
        end
        if (out_valid_q && bus.i_ready1) out_valid_d = 1'b0;
        if (retire) begin
            out_valid_d = 1'b1;
            out_data_d  = alu_res;
            out_flags_d = alu_err ? 2'b00 : {alu_c, alu_res == '0};
            out_rd_d    = rd;
            out_err_d   = alu_err;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            s1_valid_q  <= 1'b0;
            s1_instr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
            out_rd_q    <= '0;
            out_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_instr_q  <= s1_instr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
            out_rd_q    <= out_rd_d;
            out_err_q   <= out_err_d;
        end
    end

    // Write lands on the retiring edge, so the next instruction in S1 sees it.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            for (int i = 1; i < REG_COUNT; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (rd == 5'(i)) rf_q[i] <= alu_res;
            end
        end
    end

    assign bus.o_ready  = ready;
    assign bus.o_valid1 = out_valid_q;
    assign bus.o_data1  = out_data_q;
    assign bus.o_flags  = out_flags_q;
    assign bus.o_rd     = out_rd_q;
    assign bus.o_err    = out_err_q;
endmodule

// File: tb/tb_alu_core_pipe.sv
// Randomized and directed bench for alu_core_pipe with an in-order ISA model
// and a scoreboard of expected result beats {err, rd, C, Z, data}.
module tb_alu_core_pipe;
  localparam int DW  = 8;
  localparam int RC  = 16;
  localparam int MOD = 1 << DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_core_pipe_if #(.DATA_WIDTH(DW)) bus ();

  alu_core_pipe #(.DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
    .i_CLK (clk),
    .i_RSTn(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q[$];
  int          acc_q[$];
  logic [15:0] obs_q[$];
  int          rf_m[RC];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          rand_bp = 1'b0;
  bit          lat_chk = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_beat = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int rd_m(input int idx);
    return (idx == 0 || idx >= RC) ? 0 : rf_m[idx];
  endfunction

  // ISA reference: sequential execution in program order with plain integers.
  task automatic model_exec(input logic [31:0] ins, output logic [15:0] beat);
    int op, rd, a, b, im, r, c, err;
    op  = int'(ins[31:28]);
    rd  = int'(ins[27:23]);
    a   = rd_m(int'(ins[22:18]));
    b   = rd_m(int'(ins[17:13]));
    im  = int'(ins[12:0]) % MOD;
    r   = 0;
    c   = 0;
    err = 0;
    case (op)
      0: begin r = a + b; c = (r >= MOD) ? 1 : 0; end
      1: begin r = a - b; c = (a < b) ? 1 : 0; if (r < 0) r += MOD; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (b >= DW) ? 0 : (a << b);
      6: r = (b >= DW) ? 0 : (a >> b);
      7: r = im;
      8: begin r = a + im; c = (r >= MOD) ? 1 : 0; end
      default: err = 1;
    endcase
    r = r % MOD;
    if (err == 0 && rd != 0 && rd < RC) rf_m[rd] = r;
    beat = {1'(err), 5'(rd), 1'(c), (err != 0) ? 1'b0 : 1'(r == 0), 8'(r)};
  endtask

  // Monitor: samples 2 time units before each rising edge.
  always begin : monitor
    logic [15:0] eb, ob, mb;
    int acc;
    @(negedge clk);
    #3;
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      ob = {bus.o_err, bus.o_rd, bus.o_flags, bus.o_data1};
      if (prev_stall) begin
        check("hold_valid", 32'(bus.o_valid1), 1);
        check("hold_beat", 32'(ob), 32'(prev_beat));
      end
      if (bus.o_valid1 && bus.i_ready1) begin
        check("beat_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          eb  = exp_q.pop_front();
          acc = acc_q.pop_front();
          check("data", 32'(ob[7:0]), 32'(eb[7:0]));
          check("flags", 32'(ob[9:8]), 32'(eb[9:8]));
          check("rd", 32'(ob[14:10]), 32'(eb[14:10]));
          check("err", 32'(ob[15]), 32'(eb[15]));
          if (lat_chk) check("latency", 32'(cyc - acc), 2);
        end
        obs_q.push_back(ob);
      end
      if (bus.i_valid && bus.o_ready) begin
        model_exec(bus.i_instr, mb);
        exp_q.push_back(mb);
        acc_q.push_back(cyc);
      end
      prev_stall = bus.o_valid1 && !bus.i_ready1;
      prev_beat  = ob;
    end
  end

  task automatic step();
    @(negedge clk);
    if (rand_bp) bus.i_ready1 = ($urandom_range(0, 3) != 0);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [12:0] imm);
    bus.i_instr = {op, rd, rs1, rs2, imm};
    bus.i_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      #4;
      if (bus.o_ready) begin
        step();
        return;
      end
      step();
    end
    check("issue_timeout", 32'(bus.o_ready), 1);
  endtask

  task automatic idle(input int n);
    bus.i_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain();
    bus.i_valid  = 1'b0;
    rand_bp      = 1'b0;
    bus.i_ready1 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    step();
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic chk_obs(input string tag, input int i, input int data, input int flags,
                         input int rd, input int err);
    logic [15:0] e;
    e = (i < obs_q.size()) ? obs_q[i] : 16'hxxxx;
    check({tag, "_data"}, 32'(e[7:0]), 32'(data));
    check({tag, "_flags"}, 32'(e[9:8]), 32'(flags));
    check({tag, "_rd"}, 32'(e[14:10]), 32'(rd));
    check({tag, "_err"}, 32'(e[15]), 32'(err));
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.o_valid1), 0);
    check({tag, "_data"}, 32'(bus.o_data1), 0);
    check({tag, "_flags"}, 32'(bus.o_flags), 0);
    check({tag, "_rd"}, 32'(bus.o_rd), 0);
    check({tag, "_err"}, 32'(bus.o_err), 0);
    check({tag, "_ready"}, 32'(bus.o_ready), 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bus.i_instr  = '0;
    bus.i_valid  = 1'b0;
    bus.i_ready1 = 1'b1;
    for (int i = 0; i < RC; i++) rf_m[i] = 0;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load and add, back-to-back, latency 2 and 1 result/cycle
    obs_q.delete();
    lat_chk = 1'b1;
    issue(4'd7, 5'd1, 5'd0, 5'd0, 13'd5);
    issue(4'd7, 5'd2, 5'd0, 5'd0, 13'd10);
    issue(4'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    drain();
    lat_chk = 1'b0;
    chk_obs("t1_0", 0, 5, 0, 1, 0);
    chk_obs("t1_1", 1, 10, 0, 2, 0);
    chk_obs("t1_2", 2, 15, 0, 3, 0);

    // SUB borrow / zero, ADDI carry
    obs_q.delete();
    issue(4'd1, 5'd4, 5'd3, 5'd1, 13'd0);
    issue(4'd1, 5'd5, 5'd1, 5'd2, 13'd0);
    issue(4'd1, 5'd6, 5'd1, 5'd1, 13'd0);
    issue(4'd7, 5'd7, 5'd0, 5'd0, 13'd200);
    issue(4'd8, 5'd7, 5'd7, 5'd0, 13'd100);
    drain();
    chk_obs("t2_0", 0, 10, 0, 4, 0);
    chk_obs("t2_1", 1, 8'hFB, 2, 5, 0);
    chk_obs("t2_2", 2, 0, 1, 6, 0);
    chk_obs("t2_3", 3, 200, 0, 7, 0);
    chk_obs("t2_4", 4, 44, 2, 7, 0);

    // Logic, shifts, R0
    obs_q.delete();
    issue(4'd2, 5'd11, 5'd1, 5'd2, 13'd0);
    issue(4'd4, 5'd12, 5'd1, 5'd2, 13'd0);
    issue(4'd5, 5'd13, 5'd1, 5'd1, 13'd0);
    issue(4'd6, 5'd14, 5'd3, 5'd7, 13'd0);
    issue(4'd7, 5'd0, 5'd0, 5'd0, 13'd7);
    issue(4'd0, 5'd8, 5'd0, 5'd1, 13'd0);
    drain();
    chk_obs("t3_and", 0, 0, 1, 11, 0);
    chk_obs("t3_xor", 1, 15, 0, 12, 0);
    chk_obs("t3_shl", 2, 8'hA0, 0, 13, 0);
    chk_obs("t3_shr", 3, 0, 1, 14, 0);
    chk_obs("t3_ldi0", 4, 7, 0, 0, 0);
    chk_obs("t3_add0", 5, 5, 0, 8, 0);

    // Back-pressure: two accepts, then stall with output held
    obs_q.delete();
    bus.i_ready1 = 1'b0;
    issue(4'd7, 5'd1, 5'd0, 5'd0, 13'd1);
    issue(4'd7, 5'd2, 5'd0, 5'd0, 13'd2);
    bus.i_instr = {4'd7, 5'd3, 5'd0, 5'd0, 13'd3};
    bus.i_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #4;
      check("bp_ready_low", 32'(bus.o_ready), 0);
      check("bp_valid", 32'(bus.o_valid1), 1);
      check("bp_data_held", 32'(bus.o_data1), 1);
      step();
    end
    bus.i_ready1 = 1'b1;
    #4;
    check("bp_ready_release", 32'(bus.o_ready), 1);
    step();
    drain();
    chk_obs("t4_0", 0, 1, 0, 1, 0);
    chk_obs("t4_1", 1, 2, 0, 2, 0);
    chk_obs("t4_2", 2, 3, 0, 3, 0);

    // Illegal opcode leaves R9 untouched
    obs_q.delete();
    issue(4'hF, 5'd9, 5'd1, 5'd2, 13'h1FFF);
    issue(4'd0, 5'd10, 5'd9, 5'd0, 13'd0);
    drain();
    chk_obs("t5_ill", 0, 0, 0, 9, 1);
    chk_obs("t5_add", 1, 0, 1, 10, 0);

    // Reset with a result held and S1 full
    obs_q.delete();
    bus.i_ready1 = 1'b0;
    issue(4'd7, 5'd1, 5'd0, 5'd0, 13'd9);
    issue(4'd7, 5'd2, 5'd0, 5'd0, 13'd9);
    bus.i_valid = 1'b0;
    #1;
    check("pre_reset_valid", 32'(bus.o_valid1), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    acc_q.delete();
    for (int i = 0; i < RC; i++) rf_m[i] = 0;
    step();
    rst_n = 1'b1;
    bus.i_ready1 = 1'b1;
    issue(4'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    drain();
    chk_obs("t6_add", 0, 0, 1, 3, 0);

    // Random instructions, random gaps and random output back-pressure
    rand_bp = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [3:0] op;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      issue(op, 5'($urandom_range(0, 19)), 5'($urandom_range(0, 19)),
            5'($urandom_range(0, 19)), 13'($urandom_range(0, 8191)));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_core_pipe.md
# alu_core_pipe

Parametrised successor to the single-cycle `CORE` execution block. It accepts 32-bit instructions over a valid/ready handshake and executes them in a two-stage pipeline (issue, execute/writeback) against a `REG_COUNT`-entry register file. Each result is presented on a registered output port that downstream logic can back-pressure. Compared with `CORE`, it adds an immediate load/add, shifts, OR/XOR, carry/zero flags, illegal-opcode reporting and output back-pressure.

## Interface
- `DATA_WIDTH`, 8: register and datapath width, 2..32.
- `REG_COUNT`, 32: number of registers, 2..32. Register indices are 5 bits; an index `>= REG_COUNT` reads 0 and its writes are discarded.
- `i_CLK` in 1: single clock, rising edge.
- `i_RSTn` in 1: asynchronous, active-low reset.
- `i_instr` in 32: instruction `{op[3:0], rd[4:0], rs1[4:0], rs2[4:0], imm[12:0]}`.
- `i_valid` in 1: `i_instr` is valid.
- `o_ready` out 1: block accepts an instruction this cycle.
- `o_data1` out `DATA_WIDTH`: result.
- `o_valid1` out 1: `o_data1`, `o_flags`, `o_rd` and `o_err` are valid.
- `i_ready1` in 1: downstream accepts the result.
- `o_flags` out 2: `{C, Z}` of the result.
- `o_rd` out 5: destination index of the result.
- `o_err` out 1: this result came from an illegal opcode.

## Operation
- **Opcodes:**
  - 0 ADD: `rs1+rs2`
  - 1 SUB: `rs1-rs2`
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL: `rs1 << rs2`
  - 6 SHR: logical, `rs1 >> rs2`
  - 7 LDI: `imm`, zero-extended or truncated to `DATA_WIDTH`
  - 8 ADDI: `rs1 + imm`, with `imm` truncated
  - 9..15: illegal
- **Arithmetic:**
  - All results are modulo 2^`DATA_WIDTH`.
  - C is the carry-out for ADD/ADDI.
  - C is the borrow (`rs1 < rs2`, unsigned) for SUB.
  - C = 0 for all other opcodes.
  - Z = (result == 0).
- **Shifts:** if the full `rs2` value is `>= DATA_WIDTH`, the result is 0.
- **R0:** always reads 0. Writes to R0 are discarded, but the result is still output.
- **Illegal opcode:** no register write; output beat has `o_data1 = 0`, flags 0, `o_err = 1`.
- **Stage S1 (issue):** `i_valid && o_ready` latches the instruction into S1 (`s1_valid` set).
- **Stage EX:**
  - Reads operands combinationally from the register file.
  - Computes the result.
  - When the output register is free (`!o_valid1 || i_ready1`), loads the output register and writes the register file on the same edge. S1 then empties unless a new instruction is accepted on that edge.
- **`o_ready`:** `!s1_valid || !o_valid1 || i_ready1`.
- **Dependent instructions:** need no forwarding. The register write completes on the edge that retires the producer, before the consumer reads in EX.
- **Output port:** `o_valid1` clears on `i_ready1` unless a new result loads on the same edge. `o_data1`, `o_flags`, `o_rd` and `o_err` are held stable while `o_valid1 && !i_ready1`.
- **Reset (asynchronous, including mid-stream):**
  - All registers clear to 0 and `s1_valid` clears.
  - Outputs: `o_valid1 = 0`, `o_data1 = 0`, `o_flags = 0`, `o_rd = 0`, `o_err = 0`, `o_ready = 1`.
  - In-flight instructions are dropped.

## Timing
- An instruction accepted at edge N produces `o_valid1` high after edge N+1 when unstalled: latency 2 edges.
- Throughput is 1 instruction/cycle when `i_ready1` stays high.
- Back-pressure: when `i_ready1` is low, one result waits in the output register and one instruction waits in S1. `o_ready` then drops combinationally, in the same cycle.
- When `i_ready1` rises, both drain in order on successive edges. No beat is lost or duplicated.
- Simultaneous accept and retire on one edge is legal: S1 is replaced.

## Test plan
All scenarios use `DATA_WIDTH` = 8.
1. **Load and add:** LDI R1,5; LDI R2,10; ADD R3,R1,R2 back-to-back -> outputs 5, 10, 15 with `o_rd` = 1, 2, 3, flags `{0,0}`, 1 result/cycle after 2-cycle latency.
2. **SUB and flags:**
   - SUB R4,R3,R1 -> 10, C=0.
   - SUB R5,R1,R2 -> 0xFB, C=1.
   - SUB R6,R1,R1 -> 0, Z=1.
   - LDI R7,200; ADDI R7,R7,100 -> 44, C=1.
3. **Logic, shifts and R0:**
   - AND R1,R2 -> 0; XOR R1,R2 -> 15.
   - SHL R1 by R1 (5) -> 0xA0; SHR R3 by R7 (44) -> 0.
   - LDI R0,7 -> outputs 7; ADD R8,R0,R1 -> 5.
4. **Back-pressure:** `i_ready1` = 0 for 4 cycles while issuing LDI 1,2,3 -> `o_ready` low after two accepts and `o_data1` held at 1. On release, results 1, 2, 3 appear in order and the third instruction is accepted.
5. **Illegal opcode:** op 0xF with rd=9 -> `o_err` = 1, `o_data1` = 0; a subsequent ADD R10,R9,R0 -> 0.
6. **Reset mid-stream:** assert `i_RSTn` low while `o_valid1` = 1 and S1 full -> all outputs 0 immediately, `o_ready` = 1. After release, ADD R3,R1,R2 -> 0.
